// File: rtl/vadd_pkg.sv
// vadd_pkg: opcodes, element-width codes and helpers shared by vadd_minmax_pipe
package vadd_pkg;
    localparam logic [4:0] OP_ADD   = 5'd0;
    localparam logic [4:0] OP_SUB   = 5'd1;
    localparam logic [4:0] OP_RSUB  = 5'd2;
    localparam logic [4:0] OP_MINU  = 5'd3;
    localparam logic [4:0] OP_MIN   = 5'd4;
    localparam logic [4:0] OP_MAXU  = 5'd5;
    localparam logic [4:0] OP_MAX   = 5'd6;
    localparam logic [4:0] OP_SEQ   = 5'd7;
    localparam logic [4:0] OP_SNE   = 5'd8;
    localparam logic [4:0] OP_SLTU  = 5'd9;
    localparam logic [4:0] OP_SLT   = 5'd10;
    localparam logic [4:0] OP_SLEU  = 5'd11;
    localparam logic [4:0] OP_SLE   = 5'd12;
    localparam logic [4:0] OP_SGTU  = 5'd13;
    localparam logic [4:0] OP_SGT   = 5'd14;
    localparam logic [4:0] OP_SADDU = 5'd15;
    localparam logic [4:0] OP_SADD  = 5'd16;
    localparam logic [4:0] OP_SSUBU = 5'd17;
    localparam logic [4:0] OP_SSUB  = 5'd18;

    localparam logic [1:0] SEW_8  = 2'd0;
    localparam logic [1:0] SEW_16 = 2'd1;
    localparam logic [1:0] SEW_32 = 2'd2;
    localparam logic [1:0] SEW_64 = 2'd3;

    function automatic int elem_count(input logic [1:0] sew, input int width);
        return width / (8 << sew);
    endfunction
endpackage

// File: rtl/vadd_lane_slice.sv
// vadd_lane_slice: 8-bit add/sub slice; carry-in restarts at an element boundary
module vadd_lane_slice (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    input  logic       sub,
    input  logic       boundary,
    output logic [7:0] sum,
    output logic       cout,
    output logic       msb
);
    assign {cout, sum} = {1'b0, a} + {1'b0, sub ? ~b : b} + {8'd0, boundary ? sub : cin};
    assign msb = sum[7];
endmodule

// File: rtl/vadd_minmax_pipe.sv
// vadd_minmax_pipe: 3-stage vector add/sub/min/max/compare unit with valid/ready;
// define VADD_MINMAX_SAT_EN to add saturating add/sub and the out_sat flag
module vadd_minmax_pipe
    import vadd_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 32,
    parameter int SEW_WIDTH  = 2,
    parameter int OP_WIDTH   = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_vec0,
    input  logic [DATA_WIDTH-1:0] in_vec1,
    input  logic [SEW_WIDTH-1:0]  in_sew,
    input  logic [OP_WIDTH-1:0]   in_op,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_vec,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic                  out_valid,
`ifdef VADD_MINMAX_SAT_EN
    output logic                  out_sat,
`endif
    input  logic                  out_ready
);
    localparam int NL = DATA_WIDTH / 8;
    localparam int LW = $clog2(NL);

    logic                  stall;
    logic                  s0_v_q, s1_v_q, out_valid_q;
    logic [DATA_WIDTH-1:0] s0_v0_q, s0_v1_q;
    logic [SEW_WIDTH-1:0]  s0_sew_q, s1_sew_q;
    logic [OP_WIDTH-1:0]   s0_op_q, s1_op_q;
    logic [ADDR_WIDTH-1:0] s0_addr_q, s1_addr_q, out_addr_q;
    logic [DATA_WIDTH-1:0] s1_a_q, s1_b_q, s1_sum_q, out_vec_q;
    logic [NL-1:0]         s1_cout_q, s1_msb_q;
    logic [DATA_WIDTH-1:0] a_d, b_d, sum_d, res_d, bytes;
    logic [NL-1:0]         cout_d, msb_d, carry, zero, cmp_bits;
    logic [LW-1:0]         lm0, lm1, tk, eidx;
    logic                  sub_d, sa, sb, ss, ltu, lt, eq, top, cmp, is_cmp;
    logic [7:0]            la, lb, ls, lr;
`ifdef VADD_MINMAX_SAT_EN
    logic                  ovf, sat_d, out_sat_q;
    logic [7:0]            smx, smn;
`endif

    assign stall     = out_valid_q & ~out_ready;
    assign in_ready  = ~stall;
    assign out_vec   = out_vec_q;
    assign out_addr  = out_addr_q;
    assign out_valid = out_valid_q;
`ifdef VADD_MINMAX_SAT_EN
    assign out_sat   = out_sat_q;
`endif

    // lanes-per-element minus one: the low lane-index bits that stay inside one element
    assign lm0 = LW'((4'd1 << s0_sew_q) - 4'd1);
    assign lm1 = LW'((4'd1 << s1_sew_q) - 4'd1);

    // RSUB swaps operands so every subtracting op computes a + ~b + 1
    assign sub_d  = !(s0_op_q == OP_ADD || s0_op_q == OP_SADDU || s0_op_q == OP_SADD);
    assign a_d    = (s0_op_q == OP_RSUB) ? s0_v1_q : s0_v0_q;
    assign b_d    = (s0_op_q == OP_RSUB) ? s0_v0_q : s0_v1_q;
    assign carry  = {cout_d[NL-2:0], 1'b0};
    assign is_cmp = s1_op_q >= OP_SEQ && s1_op_q <= OP_SGT;

    for (genvar k = 0; k < NL; k++) begin : g_lane
        vadd_lane_slice u_slice (
            .a        (a_d[8*k +: 8]),
            .b        (b_d[8*k +: 8]),
            .cin      (carry[k]),
            .sub      (sub_d),
            .boundary ((LW'(k) & lm0) == '0),
            .sum      (sum_d[8*k +: 8]),
            .cout     (cout_d[k]),
            .msb      (msb_d[k])
        );
        assign zero[k] = s1_sum_q[8*k +: 8] == 8'd0;
    end

    // per lane: gather the flags of its element (top lane), then select the result byte or compare bit
    always_comb begin
        bytes = '0;
        cmp_bits = '0;
        res_d = '0;
        tk = '0;
        eidx = '0;
        {sa, sb, ss, ltu, lt, eq, top, cmp} = '0;
        {la, lb, ls, lr} = '0;
`ifdef VADD_MINMAX_SAT_EN
        ovf = 1'b0;
        sat_d = 1'b0;
        smx = '0;
        smn = '0;
`endif
        for (int k = 0; k < NL; k++) begin
            tk = LW'(k) | lm1;
            eidx = LW'(k) >> s1_sew_q;
            top = tk == LW'(k);
            la = s1_a_q[8*k +: 8];
            lb = s1_b_q[8*k +: 8];
            ls = s1_sum_q[8*k +: 8];
            sa = s1_a_q[{tk, 3'b111}];
            sb = s1_b_q[{tk, 3'b111}];
            ss = s1_msb_q[tk];
            ltu = !s1_cout_q[tk];
            lt = (sa != sb) ? sa : ss;
            eq = 1'b1;
            for (int j = 0; j < NL; j++)
                eq = eq & (((LW'(j) | lm1) != tk) | zero[j]);
            case (s1_op_q)
                OP_SEQ:  cmp = eq;
                OP_SNE:  cmp = !eq;
                OP_SLTU: cmp = ltu;
                OP_SLT:  cmp = lt;
                OP_SLEU: cmp = ltu | eq;
                OP_SLE:  cmp = lt | eq;
                OP_SGTU: cmp = !(ltu | eq);
                OP_SGT:  cmp = !(lt | eq);
                default: cmp = 1'b0;
            endcase
`ifdef VADD_MINMAX_SAT_EN
            ovf = 1'b0;
            smx = top ? 8'h7F : 8'hFF;
            smn = top ? 8'h80 : 8'h00;
`endif
            case (s1_op_q)
                OP_ADD, OP_SUB, OP_RSUB: lr = ls;
                OP_MINU: lr = ltu ? la : lb;
                OP_MIN:  lr = lt ? la : lb;
                OP_MAXU: lr = ltu ? lb : la;
                OP_MAX:  lr = lt ? lb : la;
`ifdef VADD_MINMAX_SAT_EN
                OP_SADDU: begin
                    ovf = s1_cout_q[tk];
                    lr = ovf ? 8'hFF : ls;
                end
                OP_SSUBU: begin
                    ovf = ltu;
                    lr = ovf ? 8'h00 : ls;
                end
                OP_SADD: begin
                    ovf = (sa == sb) && (ss != sa);
                    lr = ovf ? (sa ? smn : smx) : ls;
                end
                OP_SSUB: begin
                    ovf = (sa != sb) && (ss != sa);
                    lr = ovf ? (sa ? smn : smx) : ls;
                end
`endif
                default: lr = 8'd0;
            endcase
`ifdef VADD_MINMAX_SAT_EN
            sat_d = sat_d | ovf;
`endif
            bytes[8*k +: 8] = lr;
            if (top) cmp_bits[eidx] = cmp;
        end
        res_d = is_cmp ? DATA_WIDTH'(cmp_bits) : bytes;
    end

    // pipeline registers: the whole pipe freezes on stall; stage data loads only with its valid
    always_ff @(posedge clk) begin
        if (rst) begin
            s0_v_q <= 1'b0;
            s1_v_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_vec_q <= '0;
            out_addr_q <= '0;
`ifdef VADD_MINMAX_SAT_EN
            out_sat_q <= 1'b0;
`endif
        end else if (!stall) begin
            s0_v_q <= in_valid;
            s1_v_q <= s0_v_q;
            out_valid_q <= s1_v_q;
            if (in_valid) begin
                s0_v0_q <= in_vec0;
                s0_v1_q <= in_vec1;
                s0_sew_q <= in_sew;
                s0_op_q <= in_op;
                s0_addr_q <= in_addr;
            end
            if (s0_v_q) begin
                s1_a_q <= a_d;
                s1_b_q <= b_d;
                s1_sum_q <= sum_d;
                s1_cout_q <= cout_d;
                s1_msb_q <= msb_d;
                s1_sew_q <= s0_sew_q;
                s1_op_q <= s0_op_q;
                s1_addr_q <= s0_addr_q;
            end
            if (s1_v_q) begin
                out_vec_q <= res_d;
                out_addr_q <= s1_addr_q;
            end
`ifdef VADD_MINMAX_SAT_EN
            out_sat_q <= s1_v_q & sat_d;
`endif
        end
    end
endmodule

// File: tb/tb_vadd_minmax_pipe.sv
// tb_vadd_minmax_pipe: randomized scoreboard bench for vadd_minmax_pipe (VADD_MINMAX_SAT_EN aware)
module tb_vadd_minmax_pipe;
    import vadd_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] in_vec0 = '0, in_vec1 = '0;
    logic [1:0]  in_sew = '0;
    logic [4:0]  in_op = '0;
    logic [31:0] in_addr = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] out_vec;
    logic [31:0] out_addr;
    logic        out_valid;
    logic        out_ready = 1'b1;
`ifdef VADD_MINMAX_SAT_EN
    logic        out_sat;
    logic        last_sat = 1'b0;
`endif

    typedef struct {
        logic [63:0] vec;
        logic [31:0] addr;
        logic        sat;
        int          acc_cyc;
        int          acc_stalls;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0, fails = 0, cyc = 0, stalls = 0;
    bit          rand_rdy = 1'b0, pstall = 1'b0;
    logic [63:0] pv = '0, last_vec = '0;
    logic [31:0] pa = '0, tag = 32'd1;

    always #5 clk = ~clk;

    vadd_minmax_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_vec0   (in_vec0),
        .in_vec1   (in_vec1),
        .in_sew    (in_sew),
        .in_op     (in_op),
        .in_addr   (in_addr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_vec   (out_vec),
        .out_addr  (out_addr),
        .out_valid (out_valid),
`ifdef VADD_MINMAX_SAT_EN
        .out_sat   (out_sat),
`endif
        .out_ready (out_ready)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // element-wise reference: plain integer arithmetic per element, results packed back
    function automatic void model(input logic [4:0] op, input logic [1:0] sew,
                                  input logic [63:0] v0, input logic [63:0] v1,
                                  output logic [63:0] r, output logic sat);
        int w, ne;
        logic [63:0] m, a, b, x;
        longint sa, sb;
        logic signed [65:0] ta, tb, t, lo, hi;
        w = 8 << sew;
        ne = elem_count(sew, 64);
        m = (w == 64) ? '1 : (64'd1 << w) - 64'd1;
        r = '0;
        sat = 1'b0;
        for (int e = 0; e < ne; e++) begin
            a = (v0 >> (e * w)) & m;
            b = (v1 >> (e * w)) & m;
            sa = signed'(a << (64 - w)) >>> (64 - w);
            sb = signed'(b << (64 - w)) >>> (64 - w);
            x = '0;
            case (op)
                OP_ADD:  x = a + b;
                OP_SUB:  x = a - b;
                OP_RSUB: x = b - a;
                OP_MINU: x = (a < b) ? a : b;
                OP_MIN:  x = (sa < sb) ? a : b;
                OP_MAXU: x = (a > b) ? a : b;
                OP_MAX:  x = (sa > sb) ? a : b;
                OP_SEQ:  r[e] = a == b;
                OP_SNE:  r[e] = a != b;
                OP_SLTU: r[e] = a < b;
                OP_SLT:  r[e] = sa < sb;
                OP_SLEU: r[e] = a <= b;
                OP_SLE:  r[e] = sa <= sb;
                OP_SGTU: r[e] = a > b;
                OP_SGT:  r[e] = sa > sb;
`ifdef VADD_MINMAX_SAT_EN
                OP_SADDU, OP_SADD, OP_SSUBU, OP_SSUB: begin
                    if (op == OP_SADD || op == OP_SSUB) begin
                        ta = 66'(sa);
                        tb = 66'(sb);
                        lo = -(66'sd1 <<< (w - 1));
                        hi = (66'sd1 <<< (w - 1)) - 66'sd1;
                    end else begin
                        ta = 66'(a);
                        tb = 66'(b);
                        lo = '0;
                        hi = 66'(m);
                    end
                    t = (op == OP_SADDU || op == OP_SADD) ? ta + tb : ta - tb;
                    if (t > hi) begin
                        t = hi;
                        sat = 1'b1;
                    end else if (t < lo) begin
                        t = lo;
                        sat = 1'b1;
                    end
                    x = 64'(t);
                end
`endif
                default: ;
            endcase
            r = r | ((x & m) << (e * w));
        end
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // request monitor: every accepted request pushes its expected result
    always @(negedge clk) begin
        exp_t e;
        if (rst) exp_q.delete();
        else if (in_valid && in_ready) begin
            model(in_op, in_sew, in_vec0, in_vec1, e.vec, e.sat);
            e.addr = in_addr;
            e.acc_cyc = cyc;
            e.acc_stalls = stalls;
            exp_q.push_back(e);
        end
    end

    // result monitor: handshake, stall stability, and in-order results with latency 3 + stall cycles
    always @(negedge clk) begin
        exp_t e;
        if (rst) pstall = 1'b0;
        else begin
            check("in_ready", 64'(in_ready), 64'(!(out_valid && !out_ready)));
            if (pstall) begin
                check("hold_vec", out_vec, pv);
                check("hold_addr", 64'(out_addr), 64'(pa));
                check("hold_valid", 64'(out_valid), 64'd1);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_output: got tag %h, none expected", out_addr);
                end else begin
                    e = exp_q.pop_front();
                    check("vec", out_vec, e.vec);
                    check("addr", 64'(out_addr), 64'(e.addr));
                    check("latency", 64'(cyc - e.acc_cyc), 64'(3 + stalls - e.acc_stalls));
`ifdef VADD_MINMAX_SAT_EN
                    check("sat", 64'(out_sat), 64'(e.sat));
                    last_sat = out_sat;
`endif
                    last_vec = out_vec;
                end
            end
`ifdef VADD_MINMAX_SAT_EN
            if (!out_valid) check("sat_idle", 64'(out_sat), 64'd0);
`endif
            pstall = out_valid && !out_ready;
            pv = out_vec;
            pa = out_addr;
            if (pstall) stalls++;
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rand_rdy) out_ready = $urandom_range(0, 3) != 0;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", checks);
        $fatal(1, "watchdog");
    end

    // called and returns at posedge+1; holds the request until it is accepted
    task automatic send(input logic [4:0] op, input logic [1:0] sew, input logic [63:0] a, input logic [63:0] b);
        bit ok;
        int n = 0;
        in_op = op;
        in_sew = sew;
        in_vec0 = a;
        in_vec1 = b;
        in_addr = tag;
        tag++;
        in_valid = 1'b1;
        do begin
            @(negedge clk);
            ok = in_ready;
            n++;
            @(posedge clk);
            #1;
        end while (!ok && n < 200);
        if (!ok) begin
            checks++;
            fails++;
            $display("FAIL accept_timeout: got in_ready=0 for %0d cycles, expected 1", n);
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            fails++;
            $display("FAIL drain_timeout: got %0d results outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_vec", out_vec, 64'd0);
        check("rst_addr", 64'(out_addr), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rdy_after_rst", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        send(OP_ADD, SEW_8, 64'h01FF01FF01FF01FF, 64'h0101010101010101);
        drain();
        check("add_bytes", last_vec, 64'h0200020002000200);
        send(OP_MIN, SEW_32, 64'h80000000_00000005, 64'h00000001_00000007);
        drain();
        check("min_sew32", last_vec, 64'h80000000_00000005);
        send(OP_MINU, SEW_32, 64'h80000000_00000005, 64'h00000001_00000007);
        drain();
        check("minu_sew32", last_vec, 64'h00000001_00000005);
        send(OP_SLT, SEW_64, '1, '0);
        drain();
        check("slt_sew64", last_vec, 64'h1);
        send(OP_SLTU, SEW_64, '1, '0);
        drain();
        check("sltu_sew64", last_vec, 64'h0);
        send(OP_SEQ, SEW_8, 64'h0123456789ABCDEF, 64'h0123456789ABCDEF);
        drain();
        check("seq_sew8", last_vec, 64'hFF);
        send(5'd25, SEW_16, rnd64(), rnd64());
        drain();
        check("bad_op", last_vec, 64'h0);
`ifdef VADD_MINMAX_SAT_EN
        send(OP_SADD, SEW_8, 64'h7F7F7F7F7F7F7F7F, 64'h0101010101010101);
        drain();
        check("sadd_clamp", last_vec, 64'h7F7F7F7F7F7F7F7F);
        check("sadd_sat", 64'(last_sat), 64'd1);
        send(OP_SSUBU, SEW_8, 64'h0, 64'h0101010101010101);
        drain();
        check("ssubu_clamp", last_vec, 64'h0);
        check("ssubu_sat", 64'(last_sat), 64'd1);
`endif

        for (int op = 0; op < 32; op++)
            for (int s = 0; s < 4; s++) begin
                logic [63:0] a;
                a = rnd64();
                send(5'(op), 2'(s), a, ($urandom_range(0, 3) == 0) ? a : rnd64());
            end
        drain();

        out_ready = 1'b0;
        fork
            for (int i = 0; i < 5; i++) send(5'(i + 3), 2'(i % 4), rnd64(), rnd64());
            begin
                int n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!out_valid && n < 50);
                check("bp_valid_seen", 64'(out_valid), 64'd1);
                check("bp_in_ready", 64'(in_ready), 64'd0);
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        for (int i = 0; i < 3; i++) send(OP_ADD, 2'(i), rnd64(), rnd64());
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("flush_valid", 64'(out_valid), 64'd0);
            check("flush_vec", out_vec, 64'd0);
        end
        @(posedge clk);
        #1;
        send(OP_SUB, SEW_16, rnd64(), rnd64());
        drain();

        rand_rdy = 1'b1;
        for (int i = 0; i < 300; i++) begin
            logic [63:0] a;
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            a = rnd64();
            send(($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 14)),
                 2'($urandom_range(0, 3)), a, ($urandom_range(0, 3) == 0) ? a : rnd64());
        end
        drain();
        rand_rdy = 1'b0;
        @(posedge clk);
        #1 out_ready = 1'b1;
        repeat (5) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
